fpu_xif_ctrl: RTL and testbench

Coprocessor-side sequencer for rvfpm's CORE-V-XIF issue, commit and result channels. It accepts offloaded FP instructions into an in-order queue and tracks commit/kill per ID. Committed instructions are dispatched one at a time to the FPU execution datapath, and each result is returned to the CPU over the result handshake. It sits between the XIF ports and the FPU core.

---
 rtl/fpu_xif_pkg.sv | 28 ++
 rtl/fpu_xif_queue.sv | 81 ++++++++
 rtl/fpu_xif_ctrl.sv | 136 +++++++++++++
 tb/tb_fpu_xif_ctrl.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_xif_pkg.sv
// rtl/fpu_xif_pkg.sv - shared types and helpers for the XIF coprocessor sequencer
package fpu_xif_pkg;

  // Widest instruction ID the queue entry can carry; X_ID_WIDTH must not exceed it.
  localparam int unsigned XIF_ID_MAX = 16;

  typedef struct packed {
    logic                  valid;
    logic [XIF_ID_MAX-1:0] id;
    logic [31:0]           instr;
    logic                  wb;
    logic                  committed;
    logic                  killed;
  } xif_entry_t;

  typedef enum logic [1:0] {
    IDLE,
    DISPATCH,
    EXEC,
    RESULT
  } ctrl_state_e;

  // Pointer carries one extra wrap bit above the slot index.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fpu_xif_queue.sv
// rtl/fpu_xif_queue.sv - in-order instruction queue with commit/kill marking by ID
module fpu_xif_queue
  import fpu_xif_pkg::*;
#(
  parameter int unsigned X_ID_WIDTH  = 4,
  parameter int unsigned QUEUE_DEPTH = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  push_i,
  input  logic [X_ID_WIDTH-1:0] push_id_i,
  input  logic [31:0]           push_instr_i,
  input  logic                  push_wb_i,
  input  logic                  pop_i,
  input  logic                  commit_valid_i,
  input  logic [X_ID_WIDTH-1:0] commit_id_i,
  input  logic                  commit_kill_i,
  output logic                  full_o,
  output xif_entry_t            head_o
);

  localparam int unsigned PW = ptr_width(QUEUE_DEPTH);
  localparam int unsigned IW = PW - 1;

  xif_entry_t      ent_q [QUEUE_DEPTH];
  xif_entry_t      ent_d [QUEUE_DEPTH];
  xif_entry_t      push_ent;
  logic [PW-1:0]   head_q;
  logic [PW-1:0]   tail_q;
  logic [IW-1:0]   head_idx;
  logic [IW-1:0]   tail_idx;

  assign head_idx = head_q[IW-1:0];
  assign tail_idx = tail_q[IW-1:0];
  assign full_o   = (head_q[PW-1] != tail_q[PW-1]) && (head_idx == tail_idx);
  assign head_o   = ent_q[head_idx];

  // Next entry contents: mark matching unmarked entries, then retire the head, then append.
  always_comb begin
    ent_d    = ent_q;
    push_ent = '0;
    push_ent.valid                 = 1'b1;
    push_ent.id[X_ID_WIDTH-1:0]    = push_id_i;
    push_ent.instr                 = push_instr_i;
    push_ent.wb                    = push_wb_i;
    // A commit racing the issue of the same ID lands on the new entry directly.
    if (commit_valid_i && (push_id_i == commit_id_i)) begin
      push_ent.killed    = commit_kill_i;
      push_ent.committed = !commit_kill_i;
    end
    for (int i = 0; i < QUEUE_DEPTH; i++) begin
      if (commit_valid_i && ent_q[i].valid && !ent_q[i].committed && !ent_q[i].killed &&
          (ent_q[i].id[X_ID_WIDTH-1:0] == commit_id_i)) begin
        ent_d[i].killed    = commit_kill_i;
        ent_d[i].committed = !commit_kill_i;
      end
    end
    if (pop_i) begin
      ent_d[head_idx] = '0;
    end
    if (push_i) begin
      ent_d[tail_idx] = push_ent;
    end
  end

  // Storage and pointer registers; reset flushes every slot.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      head_q <= '0;
      tail_q <= '0;
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        ent_q[i] <= '0;
      end
    end else begin
      ent_q <= ent_d;
      if (push_i) tail_q <= tail_q + PW'(1);
      if (pop_i)  head_q <= head_q + PW'(1);
    end
  end

endmodule

// File: rtl/fpu_xif_ctrl.sv
// rtl/fpu_xif_ctrl.sv - XIF issue/commit/result sequencer in front of the FPU datapath
module fpu_xif_ctrl
  import fpu_xif_pkg::*;
#(
  parameter int unsigned X_ID_WIDTH  = 4,
  parameter int unsigned FLEN        = 32,
  parameter int unsigned QUEUE_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  issue_valid,
  output logic                  issue_ready,
  input  logic [31:0]           issue_instr,
  input  logic [X_ID_WIDTH-1:0] issue_id,
  input  logic                  dec_accept,
  input  logic                  dec_writeback,
  output logic                  issue_resp_accept,
  output logic                  issue_resp_writeback,
  input  logic                  commit_valid,
  input  logic [X_ID_WIDTH-1:0] commit_id,
  input  logic                  commit_kill,
  output logic                  exec_valid,
  input  logic                  exec_ready,
  output logic [31:0]           exec_instr,
  output logic [X_ID_WIDTH-1:0] exec_id,
  input  logic                  exec_done,
  input  logic [FLEN-1:0]       exec_data,
  output logic                  result_valid,
  input  logic                  result_ready,
  output logic [X_ID_WIDTH-1:0] result_id,
  output logic [FLEN-1:0]       result_data,
  output logic                  result_we
);

  ctrl_state_e           state_q, state_d;
  xif_entry_t            head;
  logic                  full;
  logic                  push;
  logic                  pop;
  logic                  load_exec;
  logic                  load_result;
  logic [31:0]           exec_instr_q;
  logic [X_ID_WIDTH-1:0] exec_id_q;
  logic [X_ID_WIDTH-1:0] result_id_q;
  logic [FLEN-1:0]       result_data_q;
  logic                  result_we_q;
  logic                  unused_head_id;

  assign issue_ready          = !full;
  assign issue_resp_accept    = issue_valid & dec_accept;
  assign issue_resp_writeback = issue_valid & dec_accept & dec_writeback;
  assign push                 = issue_valid & issue_ready & dec_accept;
  assign unused_head_id       = ^head.id;

  fpu_xif_queue #(
    .X_ID_WIDTH (X_ID_WIDTH),
    .QUEUE_DEPTH(QUEUE_DEPTH)
  ) u_queue (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .push_i        (push),
    .push_id_i     (issue_id),
    .push_instr_i  (issue_instr),
    .push_wb_i     (dec_writeback),
    .pop_i         (pop),
    .commit_valid_i(commit_valid),
    .commit_id_i   (commit_id),
    .commit_kill_i (commit_kill),
    .full_o        (full),
    .head_o        (head)
  );

  // Sequencing: drop killed heads, run committed heads through dispatch/exec/result.
  always_comb begin
    state_d     = state_q;
    pop         = 1'b0;
    load_exec   = 1'b0;
    load_result = 1'b0;
    case (state_q)
      IDLE: begin
        if (head.valid && head.killed) begin
          pop = 1'b1;
        end else if (head.valid && head.committed) begin
          state_d   = DISPATCH;
          load_exec = 1'b1;
        end
      end
      DISPATCH: if (exec_ready) state_d = EXEC;
      EXEC: begin
        if (exec_done) begin
          state_d     = RESULT;
          load_result = 1'b1;
        end
      end
      RESULT: begin
        if (result_ready) begin
          pop     = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; the result is tagged from the head, which stays put until popped.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      exec_instr_q  <= '0;
      exec_id_q     <= '0;
      result_id_q   <= '0;
      result_data_q <= '0;
      result_we_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (load_exec) begin
        exec_instr_q <= head.instr;
        exec_id_q    <= head.id[X_ID_WIDTH-1:0];
      end
      if (load_result) begin
        result_id_q   <= head.id[X_ID_WIDTH-1:0];
        result_data_q <= exec_data;
        result_we_q   <= head.wb;
      end
    end
  end

  assign exec_valid   = (state_q == DISPATCH);
  assign result_valid = (state_q == RESULT);
  assign exec_instr   = exec_instr_q;
  assign exec_id      = exec_id_q;
  assign result_id    = result_id_q;
  assign result_data  = result_data_q;
  assign result_we    = result_we_q;

endmodule

// File: tb/tb_fpu_xif_ctrl.sv
// tb/tb_fpu_xif_ctrl.sv - directed self-checking bench for fpu_xif_ctrl
module tb_fpu_xif_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        issue_valid, issue_ready;
  logic [31:0] issue_instr;
  logic [3:0]  issue_id;
  logic        dec_accept, dec_writeback;
  logic        issue_resp_accept, issue_resp_writeback;
  logic        commit_valid, commit_kill;
  logic [3:0]  commit_id;
  logic        exec_valid, exec_ready;
  logic [31:0] exec_instr;
  logic [3:0]  exec_id;
  logic        exec_done;
  logic [31:0] exec_data;
  logic        result_valid, result_ready;
  logic [3:0]  result_id;
  logic [31:0] result_data;
  logic        result_we;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fpu_xif_ctrl #(.X_ID_WIDTH(4), .FLEN(32), .QUEUE_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_instr(issue_instr),
    .issue_id(issue_id), .dec_accept(dec_accept), .dec_writeback(dec_writeback),
    .issue_resp_accept(issue_resp_accept), .issue_resp_writeback(issue_resp_writeback),
    .commit_valid(commit_valid), .commit_id(commit_id), .commit_kill(commit_kill),
    .exec_valid(exec_valid), .exec_ready(exec_ready), .exec_instr(exec_instr),
    .exec_id(exec_id), .exec_done(exec_done), .exec_data(exec_data),
    .result_valid(result_valid), .result_ready(result_ready), .result_id(result_id),
    .result_data(result_data), .result_we(result_we)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] id, input logic [31:0] instr, input logic wb);
    issue_valid = 1'b1; issue_id = id; issue_instr = instr;
    dec_accept = 1'b1; dec_writeback = wb;
    tick();
    issue_valid = 1'b0; dec_accept = 1'b0; dec_writeback = 1'b0;
  endtask

  task automatic commit(input logic [3:0] id, input logic kill);
    commit_valid = 1'b1; commit_id = id; commit_kill = kill;
    tick();
    commit_valid = 1'b0; commit_kill = 1'b0;
  endtask

  task automatic accept_exec();
    exec_ready = 1'b1;
    tick();
    exec_ready = 1'b0;
  endtask

  task automatic finish_exec(input logic [31:0] data);
    exec_done = 1'b1; exec_data = data;
    tick();
    exec_done = 1'b0;
  endtask

  task automatic take_result();
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL reset_issue_ready got %b exp 1", issue_ready); end
    checks++; if (exec_valid !== 1'b0) begin errors++; $display("FAIL reset_exec_valid got %b exp 0", exec_valid); end
    checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL reset_result_valid got %b exp 0", result_valid); end
    checks++; if ({exec_instr, exec_id, result_id, result_data, result_we} !== 73'd0) begin
      errors++; $display("FAIL reset_regs got %h/%h/%h/%h/%b exp all zero", exec_instr, exec_id, result_id, result_data, result_we);
    end
    rst_n = 1'b1;
    tick();
    issue_valid = 1'b1; dec_accept = 1'b0; dec_writeback = 1'b1;
    #1;
    checks++; if ({issue_resp_accept, issue_resp_writeback} !== 2'b00) begin errors++; $display("FAIL resp_reject got %b%b exp 00", issue_resp_accept, issue_resp_writeback); end
    dec_accept = 1'b1; dec_writeback = 1'b0;
    #1;
    checks++; if ({issue_resp_accept, issue_resp_writeback} !== 2'b10) begin errors++; $display("FAIL resp_accept_nowb got %b%b exp 10", issue_resp_accept, issue_resp_writeback); end
    issue_valid = 1'b0; dec_accept = 1'b0;
    #1;
  endtask

  task automatic test_single();
    issue_valid = 1'b1; issue_id = 4'd3; issue_instr = 32'h00A0_0053; dec_accept = 1'b1; dec_writeback = 1'b1;
    #1;
    checks++; if (issue_resp_writeback !== 1'b1) begin errors++; $display("FAIL single_resp_wb got %b exp 1", issue_resp_writeback); end
    tick();
    issue_valid = 1'b0; dec_accept = 1'b0; dec_writeback = 1'b0;
    commit(4'd3, 1'b0);
    checks++; if (exec_valid !== 1'b0) begin errors++; $display("FAIL single_exec_early got %b exp 0", exec_valid); end
    tick();
    checks++; if ({exec_valid, exec_id, exec_instr} !== {1'b1, 4'd3, 32'h00A0_0053}) begin
      errors++; $display("FAIL single_dispatch got v=%b id=%0d instr=%h exp v=1 id=3 instr=00a00053", exec_valid, exec_id, exec_instr);
    end
    accept_exec();
    checks++; if ({exec_valid, result_valid} !== 2'b00) begin errors++; $display("FAIL single_exec_state got %b%b exp 00", exec_valid, result_valid); end
    finish_exec(32'h3F80_0000);
    checks++; if ({result_valid, result_id, result_data, result_we} !== {1'b1, 4'd3, 32'h3F80_0000, 1'b1}) begin
      errors++; $display("FAIL single_result got v=%b id=%0d data=%h we=%b exp v=1 id=3 data=3f800000 we=1", result_valid, result_id, result_data, result_we);
    end
    checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL single_issue_ready got %b exp 1", issue_ready); end
    take_result();
    checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL single_result_drop got %b exp 0", result_valid); end
  endtask

  task automatic test_full();
    for (int i = 0; i < 4; i++) begin
      issue(4'(i), 32'h1000_0000 + 32'(i), 1'b1);
      checks++; if (issue_ready !== (i < 3)) begin errors++; $display("FAIL full_ready_%0d got %b exp %b", i, issue_ready, (i < 3)); end
    end
    commit(4'd0, 1'b0);
    tick();
    checks++; if ({exec_valid, exec_id} !== {1'b1, 4'd0}) begin errors++; $display("FAIL full_dispatch got v=%b id=%0d exp v=1 id=0", exec_valid, exec_id); end
    accept_exec();
    finish_exec(32'h4040_0000);
    checks++; if ({result_valid, result_id, issue_ready} !== {1'b1, 4'd0, 1'b0}) begin
      errors++; $display("FAIL full_result got v=%b id=%0d ready=%b exp v=1 id=0 ready=0", result_valid, result_id, issue_ready);
    end
    take_result();
    checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL full_ready_after_pop got %b exp 1", issue_ready); end
    commit(4'd1, 1'b1);
    commit(4'd2, 1'b1);
    commit(4'd3, 1'b1);
    tick(); tick();
    checks++; if ({exec_valid, result_valid} !== 2'b00) begin errors++; $display("FAIL full_drain got %b%b exp 00", exec_valid, result_valid); end
  endtask

  task automatic test_kill();
    int results_seen;
    issue(4'd5, 32'h2000_0005, 1'b1);
    issue(4'd6, 32'h2000_0006, 1'b0);
    commit(4'd5, 1'b1);
    commit(4'd6, 1'b0);
    checks++; if (exec_valid !== 1'b0) begin errors++; $display("FAIL kill_no_dispatch5 got %b exp 0", exec_valid); end
    tick();
    checks++; if ({exec_valid, exec_id} !== {1'b1, 4'd6}) begin errors++; $display("FAIL kill_dispatch6 got v=%b id=%0d exp v=1 id=6", exec_valid, exec_id); end
    accept_exec();
    finish_exec(32'h4000_0000);
    checks++; if ({result_valid, result_id, result_data, result_we} !== {1'b1, 4'd6, 32'h4000_0000, 1'b0}) begin
      errors++; $display("FAIL kill_result6 got v=%b id=%0d data=%h we=%b exp v=1 id=6 data=40000000 we=0", result_valid, result_id, result_data, result_we);
    end
    take_result();
    results_seen = 0;
    for (int c = 0; c < 6; c++) begin
      if (result_valid || exec_valid) results_seen++;
      tick();
    end
    checks++; if (results_seen !== 0) begin errors++; $display("FAIL kill_extra_activity got %0d exp 0", results_seen); end
  endtask

  task automatic test_same_cycle_commit();
    issue_valid = 1'b1; issue_id = 4'd2; issue_instr = 32'h3000_0002; dec_accept = 1'b1; dec_writeback = 1'b1;
    commit_valid = 1'b1; commit_id = 4'd2; commit_kill = 1'b0;
    tick();
    issue_valid = 1'b0; dec_accept = 1'b0; dec_writeback = 1'b0; commit_valid = 1'b0;
    tick();
    checks++; if ({exec_valid, exec_id, exec_instr} !== {1'b1, 4'd2, 32'h3000_0002}) begin
      errors++; $display("FAIL samecyc_dispatch got v=%b id=%0d instr=%h exp v=1 id=2 instr=30000002", exec_valid, exec_id, exec_instr);
    end
    accept_exec();
    finish_exec(32'h1234_5678);
    checks++; if ({result_valid, result_id, result_data, result_we} !== {1'b1, 4'd2, 32'h1234_5678, 1'b1}) begin
      errors++; $display("FAIL samecyc_result got v=%b id=%0d data=%h we=%b exp v=1 id=2 data=12345678 we=1", result_valid, result_id, result_data, result_we);
    end
    take_result();
  endtask

  task automatic test_backpressure();
    issue(4'd7, 32'h4000_0007, 1'b1);
    issue(4'd8, 32'h4000_0008, 1'b1);
    commit(4'd7, 1'b0);
    commit(4'd8, 1'b0);
    checks++; if ({exec_valid, exec_id} !== {1'b1, 4'd7}) begin errors++; $display("FAIL bp_dispatch7 got v=%b id=%0d exp v=1 id=7", exec_valid, exec_id); end
    accept_exec();
    finish_exec(32'hC049_0FDB);
    for (int c = 0; c < 5; c++) begin
      checks++;
      if ({result_valid, result_id, result_data, exec_valid} !== {1'b1, 4'd7, 32'hC049_0FDB, 1'b0}) begin
        errors++; $display("FAIL bp_hold_%0d got v=%b id=%0d data=%h ev=%b exp v=1 id=7 data=c0490fdb ev=0", c, result_valid, result_id, result_data, exec_valid);
      end
      tick();
    end
    take_result();
    checks++; if ({result_valid, exec_valid} !== 2'b00) begin errors++; $display("FAIL bp_after_hs got %b%b exp 00", result_valid, exec_valid); end
    tick();
    checks++; if ({exec_valid, exec_id} !== {1'b1, 4'd8}) begin errors++; $display("FAIL bp_dispatch8 got v=%b id=%0d exp v=1 id=8", exec_valid, exec_id); end
    accept_exec();
    finish_exec(32'h0000_0008);
    take_result();
  endtask

  task automatic test_reset_mid_exec();
    int activity;
    issue(4'd9, 32'h5000_0009, 1'b1);
    issue(4'd10, 32'h5000_000A, 1'b1);
    commit(4'd9, 1'b0);
    tick();
    accept_exec();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checks++; if ({issue_ready, exec_valid, result_valid} !== 3'b100) begin
      errors++; $display("FAIL rstmid_flags got rdy=%b ev=%b rv=%b exp rdy=1 ev=0 rv=0", issue_ready, exec_valid, result_valid);
    end
    checks++; if ({exec_instr, exec_id, result_id, result_data, result_we} !== 73'd0) begin
      errors++; $display("FAIL rstmid_regs got %h/%h/%h/%h/%b exp all zero", exec_instr, exec_id, result_id, result_data, result_we);
    end
    finish_exec(32'hDEAD_BEEF);
    commit(4'd10, 1'b0);
    activity = 0;
    for (int c = 0; c < 4; c++) begin
      if (result_valid || exec_valid) activity++;
      tick();
    end
    checks++; if (activity !== 0) begin errors++; $display("FAIL rstmid_ghost got %0d exp 0", activity); end
  endtask

  initial begin
    rst_n = 1'b0; issue_valid = 1'b0; issue_instr = '0; issue_id = '0;
    dec_accept = 1'b0; dec_writeback = 1'b0; commit_valid = 1'b0; commit_id = '0;
    commit_kill = 1'b0; exec_ready = 1'b0; exec_done = 1'b0; exec_data = '0; result_ready = 1'b0;
    test_reset();
    test_single();
    test_full();
    test_kill();
    test_same_cycle_commit();
    test_backpressure();
    test_reset_mid_exec();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
